// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline boundary: 2-entry elastic buffer (main + skid) with flush,
// store byte-lane preparation and head-entry forwarding. Optional: EXMEM_MISALIGN_CHK_EN.
module ex_mem_reg #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [RAW-1:0]  rd_addr,
    input  logic            reg_write,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      mem_funct3,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    output logic [RAW-1:0]  mem_rd,
    output logic            mem_reg_write,
    output logic            mem_rd_en,
    output logic            mem_wr_en,
    output logic [2:0]      mem_f3,
    output logic            fwd_valid,
    output logic [RAW-1:0]  fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            fwd_is_load
`ifdef EXMEM_MISALIGN_CHK_EN
    ,
    output logic            mem_misalign
`endif
);

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [3:0]      be;
        logic [RAW-1:0]  rd;
        logic            rw;
        logic            ld;
        logic            rde;
        logic            wre;
        logic [2:0]      f3;
`ifdef EXMEM_MISALIGN_CHK_EN
        logic            mis;
`endif
    } entry_t;

    entry_t main_q;
    entry_t skid_q;
    entry_t main_d;
    entry_t skid_d;
    entry_t ent_in;

    logic main_valid;
    logic skid_valid;
    logic mv_d;
    logic sv_d;
    logic ready_q;

    logic accept;
    logic pop;

    logic [1:0]      a;
    logic [3:0]      be;
    logic [XLEN-1:0] wd;
`ifdef EXMEM_MISALIGN_CHK_EN
    logic            mis;
`endif

    assign accept = ex_valid & ready_q;
    assign pop    = main_valid & mem_ready;

    // Build the incoming entry: byte lanes and replicated store data
    always_comb begin
        a  = alu_result[1:0];
        be = 4'b0000;
        wd = rs2_data;
        case (mem_funct3)
            3'b000, 3'b100: begin
                be = 4'b0001 << a;
                wd = {4{rs2_data[7:0]}};
            end
            3'b001, 3'b101: begin
                be = a[1] ? 4'b1100 : 4'b0011;
                wd = {2{rs2_data[15:0]}};
            end
            3'b010: begin
                be = 4'b1111;
            end
            default: begin
                be = 4'b0000;
            end
        endcase

`ifdef EXMEM_MISALIGN_CHK_EN
        mis = (mem_read | mem_write)
            & (((mem_funct3[1:0] == 2'b01) & a[0])
             | ((mem_funct3 == 3'b010) & (a != 2'b00)));
`endif

        ent_in       = '0;
        ent_in.addr  = alu_result;
        ent_in.wdata = wd;
        ent_in.rd    = rd_addr;
        ent_in.rw    = reg_write;
        ent_in.ld    = mem_read;
        ent_in.f3    = mem_funct3;
`ifdef EXMEM_MISALIGN_CHK_EN
        ent_in.mis   = mis;
        ent_in.be    = (mem_write & ~mis) ? be : 4'b0000;
        ent_in.wre   = mem_write & ~mis;
        ent_in.rde   = mem_read & ~mis;
`else
        ent_in.be    = mem_write ? be : 4'b0000;
        ent_in.wre   = mem_write;
        ent_in.rde   = mem_read;
`endif
    end

    // Steer captures between main and skid; flush overrides everything
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        mv_d   = main_valid;
        sv_d   = skid_valid;
        if (flush) begin
            mv_d = 1'b0;
            sv_d = 1'b0;
        end else if (pop && skid_valid) begin
            main_d = skid_q;
            mv_d   = 1'b1;
            sv_d   = accept;
            if (accept) begin
                skid_d = ent_in;
            end
        end else if (accept && (!main_valid || pop)) begin
            main_d = ent_in;
            mv_d   = 1'b1;
        end else if (accept) begin
            skid_d = ent_in;
            sv_d   = 1'b1;
        end else if (pop) begin
            mv_d = 1'b0;
        end
    end

    // Occupancy and ready are registered so mem_ready never reaches ex_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            main_valid <= mv_d;
            skid_valid <= sv_d;
            ready_q    <= ~sv_d;
        end
    end

    // Entry payload storage; stale data after flush is harmless
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign ex_ready      = ready_q;
    assign mem_valid     = main_valid;
    assign mem_addr      = main_q.addr;
    assign mem_wdata     = main_q.wdata;
    assign mem_be        = main_q.be;
    assign mem_rd        = main_q.rd;
    assign mem_reg_write = main_q.rw;
    assign mem_rd_en     = main_q.rde;
    assign mem_wr_en     = main_q.wre;
    assign mem_f3        = main_q.f3;

    assign fwd_valid   = main_valid & main_q.rw & (main_q.rd != '0) & ~main_q.ld;
    assign fwd_rd      = main_q.rd;
    assign fwd_data    = main_q.addr;
    assign fwd_is_load = main_valid & main_q.ld & (main_q.rd != '0);

`ifdef EXMEM_MISALIGN_CHK_EN
    assign mem_misalign = main_q.mis;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: driver pushes expected entries on accept,
// monitor pops/compares head on each MEM consume. Honours EXMEM_MISALIGN_CHK_EN.
module tb_ex_mem_reg;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_funct3;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [2:0]  mem_f3;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        fwd_is_load;
`ifdef EXMEM_MISALIGN_CHK_EN
    logic        mem_misalign;
`endif

    ex_mem_reg dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_result(alu_result), .rs2_data(rs2_data), .rd_addr(rd_addr),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_funct3(mem_funct3), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_rd_en(mem_rd_en),
        .mem_wr_en(mem_wr_en), .mem_f3(mem_f3), .fwd_valid(fwd_valid),
        .fwd_rd(fwd_rd), .fwd_data(fwd_data), .fwd_is_load(fwd_is_load)
`ifdef EXMEM_MISALIGN_CHK_EN
        , .mem_misalign(mem_misalign)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [4:0]  rd;
        logic        rw;
        logic        ld;
        logic        rde;
        logic        wre;
        logic [2:0]  f3;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pend = 0;
    bit   mdl_ready = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: what MEM should see for an instruction, from the ISA rules
    function automatic exp_t mk(logic [31:0] alu, logic [31:0] rs2,
                                logic [4:0] rd, logic rw, logic ld,
                                logic st, logic [2:0] f3);
        exp_t e;
        int   off;
        bit   mis;
        off = int'(alu % 4);
        e.addr = alu;
        e.rd = rd;
        e.rw = rw;
        e.ld = ld;
        e.f3 = f3;
        e.wdata = rs2;
        e.be = 4'd0;
        mis = 1'b0;
        if (f3 == 3'd0 || f3 == 3'd4) begin
            e.be = 4'(1 << off);
            e.wdata = (rs2 & 32'hFF) * 32'h0101_0101;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            e.be = 4'(3 << (2 * (off / 2)));
            e.wdata = (rs2 & 32'hFFFF) * 32'h0001_0001;
            mis = (off % 2) != 0;
        end else if (f3 == 3'd2) begin
            e.be = 4'd15;
            mis = off != 0;
        end
`ifdef EXMEM_MISALIGN_CHK_EN
        mis = mis && (ld || st);
`else
        mis = 1'b0;
`endif
        e.mis = mis;
        if (!st || mis) e.be = 4'd0;
        e.wre = st && !mis;
        e.rde = ld && !mis;
        return e;
    endfunction

    // One cycle of stimulus, applied 1ns after the rising edge
    task automatic slot(bit v, logic [31:0] alu, logic [31:0] rs2,
                        logic [4:0] rd, bit rw, bit ld, bit st,
                        logic [2:0] f3, bit mr, bit fl);
        @(posedge clk);
        #1;
        ex_valid = v;
        alu_result = alu;
        rs2_data = rs2;
        rd_addr = rd;
        reg_write = rw;
        mem_read = ld;
        mem_write = st;
        mem_funct3 = f3;
        mem_ready = mr;
        flush = fl;
        pend = 0;
        if (v && mdl_ready && !fl) begin
            exp_q.push_back(mk(alu, rs2, rd, rw, ld, st, f3));
            pend = 1;
        end
    endtask

    task automatic idle(bit mr);
        slot(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, mr, 1'b0);
    endtask

    // Monitor: compare visible head and ready, consume on pop, apply flush
    initial begin
        int   held;
        exp_t h;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                held = exp_q.size() - pend;
                chk("ex_ready", ex_ready, mdl_ready);
                chk("mem_valid", mem_valid, held > 0);
                if (held > 0) begin
                    h = exp_q[0];
                    chk("mem_addr", mem_addr, h.addr);
                    chk("mem_wdata", mem_wdata, h.wdata);
                    chk("mem_be", mem_be, h.be);
                    chk("mem_rd", mem_rd, h.rd);
                    chk("mem_reg_write", mem_reg_write, h.rw);
                    chk("mem_rd_en", mem_rd_en, h.rde);
                    chk("mem_wr_en", mem_wr_en, h.wre);
                    chk("mem_f3", mem_f3, h.f3);
`ifdef EXMEM_MISALIGN_CHK_EN
                    chk("mem_misalign", mem_misalign, h.mis);
`endif
                    chk("fwd_valid", fwd_valid, h.rw && h.rd != 0 && !h.ld);
                    chk("fwd_is_load", fwd_is_load, h.ld && h.rd != 0);
                    chk("fwd_rd", fwd_rd, h.rd);
                    chk("fwd_data", fwd_data, h.addr);
                end else begin
                    chk("fwd_valid_empty", fwd_valid, 0);
                    chk("fwd_is_load_empty", fwd_is_load, 0);
                end
                if (flush) exp_q.delete();
                else if (held > 0 && mem_ready) void'(exp_q.pop_front());
                mdl_ready = exp_q.size() < 2;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        ex_valid = 1'b0;
        alu_result = '0;
        rs2_data = '0;
        rd_addr = '0;
        reg_write = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_funct3 = '0;
        mem_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_mem_ctrl", {mem_rd, mem_reg_write, mem_rd_en, mem_wr_en, mem_f3}, 0);
        chk("rst_fwd", {fwd_valid, fwd_rd, fwd_data, fwd_is_load}, 0);
        rst_n = 1'b1;
        idle(1'b1);

        // Store byte / half lanes
        slot(1, 32'h1003, 32'hAABBCCDD, 5'd0, 0, 0, 1, 3'b000, 1, 0);
        idle(1'b1);
        chk("sb_be", mem_be, 4'b1000);
        chk("sb_wdata", mem_wdata, 32'hDDDDDDDD);
        slot(1, 32'h1002, 32'hAABBCCDD, 5'd0, 0, 0, 1, 3'b001, 1, 0);
        idle(1'b1);
        chk("sh_be", mem_be, 4'b1100);
        chk("sh_wdata", mem_wdata, 32'hCCDDCCDD);

        // Forwarding
        slot(1, 32'h1234, 32'h0, 5'd5, 1, 0, 0, 3'b000, 1, 0);
        idle(1'b1);
        chk("add_fwd_valid", fwd_valid, 1);
        chk("add_fwd_rd", fwd_rd, 5);
        chk("add_fwd_data", fwd_data, 32'h1234);
        slot(1, 32'h0100, 32'h0, 5'd5, 1, 1, 0, 3'b010, 1, 0);
        idle(1'b1);
        chk("lw_fwd_valid", fwd_valid, 0);
        chk("lw_fwd_is_load", fwd_is_load, 1);
        slot(1, 32'h0104, 32'h0, 5'd0, 1, 1, 0, 3'b010, 1, 0);
        idle(1'b1);
        chk("rd0_fwd", {fwd_valid, fwd_is_load}, 0);

`ifdef EXMEM_MISALIGN_CHK_EN
        slot(1, 32'h2001, 32'h11223344, 5'd0, 0, 0, 1, 3'b010, 1, 0);
        idle(1'b1);
        chk("sw_misalign", mem_misalign, 1);
        chk("sw_mis_be", mem_be, 0);
        chk("sw_mis_wr_en", mem_wr_en, 0);
`endif

        // Backpressure: two entries fill the buffer
        slot(1, 32'hA0, 32'h1, 5'd1, 1, 0, 0, 3'b000, 0, 0);
        slot(1, 32'hB0, 32'h2, 5'd2, 1, 0, 0, 3'b000, 0, 0);
        idle(1'b0);
        chk("bp_ex_ready_low", ex_ready, 0);
        repeat (3) idle(1'b1);
        chk("bp_ex_ready_high", ex_ready, 1);

        // Flush with two held and a live incoming entry
        slot(1, 32'hC0, 32'h3, 5'd3, 1, 0, 0, 3'b000, 0, 0);
        slot(1, 32'hC4, 32'h4, 5'd4, 1, 0, 0, 3'b000, 0, 0);
        slot(1, 32'hC8, 32'h5, 5'd6, 1, 0, 0, 3'b000, 0, 1);
        idle(1'b1);
        chk("flush_mem_valid", mem_valid, 0);
        chk("flush_ex_ready", ex_ready, 1);
        repeat (2) idle(1'b1);

        // Back-to-back stream of 8
        for (int i = 0; i < 8; i++) begin
            slot(1, 32'h300 + 32'(i * 4), $urandom, 5'(i + 1), 1, 0, 0, 3'b010, 1, 0);
            chk("stream_ex_ready", ex_ready, 1);
        end
        repeat (2) idle(1'b1);

        // Asynchronous reset with a store held
        slot(1, 32'h40, 32'h55667788, 5'd0, 0, 0, 1, 3'b010, 0, 0);
        idle(1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        ex_valid = 1'b0;
        exp_q.delete();
        pend = 0;
        mdl_ready = 1'b1;
        #1;
        chk("arst_mem_valid", mem_valid, 0);
        chk("arst_ex_ready", ex_ready, 1);
        chk("arst_mem_be", mem_be, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        slot(1, 32'h77, 32'h0, 5'd7, 1, 0, 0, 3'b000, 0, 0);
        idle(1'b1);
        chk("post_rst_latency", mem_valid, 1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bit ld;
            bit st;
            ld = ($urandom_range(0, 2) == 0);
            st = !ld && ($urandom_range(0, 1) == 0);
            slot($urandom_range(0, 9) < 7, $urandom, $urandom,
                 5'($urandom_range(0, 31)), 1'($urandom), ld, st,
                 3'($urandom_range(0, 7)),
                 (i % 300 < 150) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3),
                 $urandom_range(0, 40) == 0);
        end
        repeat (4) idle(1'b1);
        @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
EX→MEM pipeline boundary. Sits directly downstream of the EX-stage ALU and captures its 32-bit result, plus store data and memory/writeback control. It also prepares byte enables and lane-replicated store data for the data memory. The block is a 2-entry elastic buffer (main + skid) with a valid/ready handshake and a synchronous flush. It also exports the head entry for EX-stage operand forwarding.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
RAW, 5, register-address width.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of all held and incoming entries
ex_valid  in  1  EX presents an entry
ex_ready  out  1  block can accept; registered
alu_result  in  XLEN  ALU output (memory address for ld/st)
rs2_data  in  XLEN  store data
rd_addr  in  RAW  destination register
reg_write  in  1  writeback enable
mem_read  in  1  load
mem_write  in  1  store
mem_funct3  in  3  access size/sign (RV32I funct3)
mem_valid  out  1  head entry valid
mem_ready  in  1  MEM consumes head
mem_addr  out  XLEN  registered alu_result
mem_wdata  out  XLEN  lane-replicated store data
mem_be  out  4  byte enables
mem_rd  out  RAW
mem_reg_write, mem_rd_en, mem_wr_en  out  1 each  registered control
mem_f3  out  3  registered funct3
fwd_valid  out  1  head forwardable ALU result
fwd_rd  out  RAW  forward destination
fwd_data  out  XLEN  forward value
fwd_is_load  out  1  head is a load to rd≠0 (load-use hazard)

Behaviour:
- Reset (rst_n=0, async):
  - main_valid=0, skid_valid=0, ex_ready=1.
  - All data/control outputs are 0.
- Handshake rules:
  - accept = ex_valid & ex_ready.
  - pop = mem_valid & mem_ready.
  - mem_valid = main_valid.
  - ex_ready = !skid_valid, registered; no combinational path from mem_ready.
- Capture steering:
  - accept & (!main_valid | pop) → entry goes to main.
  - accept & main_valid & !pop → entry goes to skid.
  - pop & skid_valid → skid moves to main; a concurrent accept then goes to skid.
  - pop & !skid_valid & !accept → main_valid=0.
- Latency and throughput:
  - Minimum latency is 1 cycle.
  - Full throughput (1/clk) when mem_ready stays high.
  - Ordering is strictly FIFO.
- Flush:
  - Clears main_valid and skid_valid.
  - Discards any same-cycle accept; flush has priority over accept and pop.
  - ex_ready=1 on the next cycle.
  - Data registers may retain stale values.
- Byte lanes, computed at capture and held with the entry; a = alu_result[1:0]:
  - f3 = 000/100 (byte): mem_be = 0001<<a; wdata = {4{rs2[7:0]}}.
  - f3 = 001/101 (half): mem_be = 0011<<(a[1]*2); wdata = {2{rs2[15:0]}}.
  - f3 = 010 (word): mem_be = 1111; wdata = rs2.
  - Other f3 values: mem_be = 0000.
  - mem_be is forced to 0000 when mem_write=0.
- Forwarding:
  - fwd_valid = main_valid & reg_write & (rd≠0) & !mem_read.
  - fwd_rd = main rd; fwd_data = main alu_result.
  - fwd_is_load = main_valid & mem_read & (rd≠0).
- Simultaneous events:
  - Accept+pop with 1 entry held: occupancy stays 1 and the new entry becomes head.
  - Full (both entries held) with pop: ex_ready rises next cycle.
- Reset mid-operation drops all entries immediately.

Optional Feature:
Macro: EXMEM_MISALIGN_CHK_EN.
- With the macro, an extra output mem_misalign (1 bit) is added and registered with the entry. It is set for:
  - a half access (f3 001/101) with a[0]=1;
  - a word access (f3 010) with a≠00;
  - only when mem_read|mem_write.
- A misaligned store forces mem_be=0000 and mem_wr_en=0.
- A misaligned load forces mem_rd_en=0.
- Without the macro there is no mem_misalign port, and misaligned addresses pass through with the computed byte enables.

Test Plan:
- Reset with rst_n=0 mid-stream → mem_valid=0, ex_ready=1, mem_be=0 asynchronously; after release, the first accepted entry appears 1 cycle later.
- Back-to-back stream of 8 entries, mem_ready=1 → outputs appear in order, one per cycle, and ex_ready never drops.
- Backpressure: mem_ready=0 while 2 entries are accepted → ex_ready=0 next cycle; raise mem_ready → entries A, B pop in order, then ex_ready=1.
- Store SB, alu_result=0x1003, rs2=0xAABBCCDD → mem_be=1000, mem_wdata=0xDDDDDDDD. SH at 0x1002 → mem_be=1100, mem_wdata=0xCCDDCCDD.
- Forwarding: ADD to rd=5 with result 0x1234 at head → fwd_valid=1, fwd_rd=5, fwd_data=0x1234. LW to rd=5 → fwd_valid=0, fwd_is_load=1. rd=0 → both 0.
- Flush asserted with 2 entries held and ex_valid=1 → mem_valid=0 and ex_ready=1 next cycle, and no flushed entry ever appears. With EXMEM_MISALIGN_CHK_EN, SW at 0x2001 → mem_misalign=1, mem_be=0000, mem_wr_en=0.
